// File: rtl/ex_stage.sv
// Execute stage with EX/MEM pipeline register.
// Owns HI/LO and the iterative multiply/divide unit.
module ex_stage #(
    parameter int          DW       = 32,
    parameter logic [31:0] DIV0_LO  = 32'hFFFFFFFF,
    parameter bit          OVF_TRAP = 1'b1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [DW-1:0] next_PC2_3,
    input  logic [5:0]    OP2_3,
    input  logic [5:0]    Funct2_3,
    input  logic [DW-1:0] Rdata12_3,
    input  logic [DW-1:0] Rdata22_3,
    input  logic [DW-1:0] imm2_3,
    input  logic [4:0]    Wreg_addr2_3,
    input  logic          RegWrite2_3,
    output logic [DW-1:0] ALU_res3_4,
    output logic [DW-1:0] Rdata23_4,
    output logic [4:0]    Wreg_addr3_4,
    output logic          RegWrite3_4,
    output logic [5:0]    OP3_4,
    output logic          stall,
    output logic          md_busy,
    output logic          ovf
);

    localparam logic [5:0] OP_R     = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_SRA   = 6'h03;
    localparam logic [5:0] F_JR    = 6'h08;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_SLTU  = 6'h2B;

    typedef enum logic {IDLE, BUSY} md_state_t;

    md_state_t     state, state_nx;
    logic [4:0]    cnt;
    logic [DW-1:0] hi, lo;
    logic [DW-1:0] acc_hi, acc_lo, opb, dvd;
    logic          is_div, neg_q, neg_r, div0;

    logic [DW-1:0] rs, rt;
    logic          is_r, is_md, is_hilo, md_start;
    logic          signed_op, md_last;

    assign rs = Rdata12_3;
    assign rt = Rdata22_3;

    assign is_r  = (OP2_3 == OP_R);
    assign is_md = is_r && (Funct2_3 == F_MULT || Funct2_3 == F_MULTU ||
                            Funct2_3 == F_DIV  || Funct2_3 == F_DIVU);
    assign is_hilo = is_md || (is_r &&
        (Funct2_3 == F_MFHI || Funct2_3 == F_MTHI ||
         Funct2_3 == F_MFLO || Funct2_3 == F_MTLO));

    assign md_busy  = (state == BUSY);
    assign md_last  = md_busy && (cnt == 5'd31);
    assign stall    = md_busy && is_hilo;
    assign md_start = (state == IDLE) && is_md;

    assign signed_op = (Funct2_3 == F_MULT) || (Funct2_3 == F_DIV);

    logic [DW-1:0] sum_rr, dif_rr, sum_ri, imm_z;
    logic [4:0]    shamt;

    assign sum_rr = rs + rt;
    assign dif_rr = rs - rt;
    assign sum_ri = rs + imm2_3;
    assign imm_z  = {{(DW-16){1'b0}}, imm2_3[15:0]};
    assign shamt  = imm2_3[10:6];

    logic [DW-1:0] alu_res;
    logic          wr_en, ovf_raw, ovf_c;

    // ALU result, write enable and raw overflow for the EX instruction
    always_comb begin
        alu_res = '0;
        wr_en   = RegWrite2_3;
        ovf_raw = 1'b0;
        if (is_r) begin
            unique case (Funct2_3)
                F_ADD: begin
                    alu_res = sum_rr;
                    ovf_raw = (rs[DW-1] == rt[DW-1]) &&
                              (sum_rr[DW-1] != rs[DW-1]);
                end
                F_ADDU: alu_res = sum_rr;
                F_SUB: begin
                    alu_res = dif_rr;
                    ovf_raw = (rs[DW-1] != rt[DW-1]) &&
                              (dif_rr[DW-1] != rs[DW-1]);
                end
                F_SUBU: alu_res = dif_rr;
                F_AND:  alu_res = rs & rt;
                F_OR:   alu_res = rs | rt;
                F_XOR:  alu_res = rs ^ rt;
                F_NOR:  alu_res = ~(rs | rt);
                F_SLT:  alu_res = {{(DW-1){1'b0}},
                                   $signed(rs) < $signed(rt)};
                F_SLTU: alu_res = {{(DW-1){1'b0}}, rs < rt};
                F_SLL:  alu_res = rt << shamt;
                F_SRL:  alu_res = rt >> shamt;
                F_SRA:  alu_res = $unsigned($signed(rt) >>> shamt);
                F_MFHI: alu_res = hi;
                F_MFLO: alu_res = lo;
                F_JR:   alu_res = '0;
                F_MTHI, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU:
                    wr_en = 1'b0;
                default: alu_res = '0;
            endcase
        end else begin
            unique case (OP2_3)
                OP_ADDI: begin
                    alu_res = sum_ri;
                    ovf_raw = (rs[DW-1] == imm2_3[DW-1]) &&
                              (sum_ri[DW-1] != rs[DW-1]);
                end
                OP_ADDIU: alu_res = sum_ri;
                OP_SLTI:  alu_res = {{(DW-1){1'b0}},
                                     $signed(rs) < $signed(imm2_3)};
                OP_SLTIU: alu_res = {{(DW-1){1'b0}}, rs < imm2_3};
                OP_ANDI:  alu_res = rs & imm_z;
                OP_ORI:   alu_res = rs | imm_z;
                OP_XORI:  alu_res = rs ^ imm_z;
                OP_LUI:   alu_res = {imm2_3[15:0], {(DW-16){1'b0}}};
                OP_LW, OP_SW: alu_res = sum_ri;
                OP_JAL:   alu_res = next_PC2_3;
                default:  alu_res = '0;
            endcase
        end
    end

    assign ovf_c = ovf_raw & OVF_TRAP;

    logic [DW:0]     mul_sum, div_sh, div_dif;
    logic            div_ge;
    logic [DW-1:0]   step_hi, step_lo, fin_hi, fin_lo;
    logic [DW-1:0]   mag_a, mag_b;
    logic [2*DW-1:0] prod, prod_fix;

    // One shift-add / restoring-subtract step plus final sign fix-up
    always_comb begin
        mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
        div_sh  = {acc_hi, acc_lo[DW-1]};
        div_dif = div_sh - {1'b0, opb};
        div_ge  = ~div_dif[DW];
        if (is_div) begin
            step_hi = div_ge ? div_dif[DW-1:0] : div_sh[DW-1:0];
            step_lo = {acc_lo[DW-2:0], div_ge};
        end else begin
            step_hi = mul_sum[DW:1];
            step_lo = {mul_sum[0], acc_lo[DW-1:1]};
        end
        prod     = {step_hi, step_lo};
        prod_fix = neg_q ? -prod : prod;
        if (!is_div) begin
            fin_hi = prod_fix[2*DW-1:DW];
            fin_lo = prod_fix[DW-1:0];
        end else if (div0) begin
            fin_hi = dvd;
            fin_lo = DIV0_LO[DW-1:0];
        end else begin
            fin_hi = neg_r ? -step_hi : step_hi;
            fin_lo = neg_q ? -step_lo : step_lo;
        end
        mag_a = (signed_op && rs[DW-1]) ? -rs : rs;
        mag_b = (signed_op && rt[DW-1]) ? -rt : rt;
    end

    // Mult/div FSM state register
    always_ff @(negedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nx;
    end

    // Mult/div FSM next state
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (md_start) state_nx = BUSY;
            BUSY: if (cnt == 5'd31) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand capture and iteration datapath
    always_ff @(negedge CLK or posedge RST) begin
        if (RST) begin
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            opb    <= '0;
            dvd    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
        end else if (md_start) begin
            is_div <= Funct2_3[1];
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= Funct2_3[1] ? mag_a : mag_b;
            opb    <= Funct2_3[1] ? mag_b : mag_a;
            dvd    <= rs;
            neg_q  <= signed_op && (rs[DW-1] ^ rt[DW-1]);
            neg_r  <= signed_op && rs[DW-1];
            div0   <= (rt == '0);
        end else if (md_busy) begin
            cnt    <= cnt + 5'd1;
            acc_hi <= step_hi;
            acc_lo <= step_lo;
        end
    end

    // HI/LO: final mult/div write or MTHI/MTLO
    always_ff @(negedge CLK or posedge RST) begin
        if (RST) begin
            hi <= '0;
            lo <= '0;
        end else if (md_last) begin
            hi <= fin_hi;
            lo <= fin_lo;
        end else if (!stall && is_r && Funct2_3 == F_MTHI) begin
            hi <= rs;
        end else if (!stall && is_r && Funct2_3 == F_MTLO) begin
            lo <= rs;
        end
    end

    // EX/MEM register; bubble while stalled
    always_ff @(negedge CLK or posedge RST) begin
        if (RST) begin
            ALU_res3_4   <= '0;
            Rdata23_4    <= '0;
            Wreg_addr3_4 <= '0;
            RegWrite3_4  <= 1'b0;
            OP3_4        <= '0;
            ovf          <= 1'b0;
        end else if (stall) begin
            ALU_res3_4   <= '0;
            Rdata23_4    <= '0;
            Wreg_addr3_4 <= '0;
            RegWrite3_4  <= 1'b0;
            OP3_4        <= '0;
            ovf          <= 1'b0;
        end else begin
            ALU_res3_4   <= alu_res;
            Rdata23_4    <= rt;
            Wreg_addr3_4 <= Wreg_addr2_3;
            RegWrite3_4  <= wr_en & ~ovf_c;
            OP3_4        <= OP2_3;
            ovf          <= ovf_c;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Testbench for ex_stage: vector table plus
// mult/div, stall and reset sequences.
module tb_ex_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] next_PC2_3, Rdata12_3, Rdata22_3, imm2_3;
    logic [5:0]  OP2_3, Funct2_3;
    logic [4:0]  Wreg_addr2_3;
    logic        RegWrite2_3;
    logic [31:0] ALU_res3_4, Rdata23_4;
    logic [4:0]  Wreg_addr3_4;
    logic        RegWrite3_4;
    logic [5:0]  OP3_4;
    logic        stall, md_busy, ovf;

    ex_stage dut (
        .CLK(CLK), .RST(RST),
        .next_PC2_3(next_PC2_3), .OP2_3(OP2_3),
        .Funct2_3(Funct2_3), .Rdata12_3(Rdata12_3),
        .Rdata22_3(Rdata22_3), .imm2_3(imm2_3),
        .Wreg_addr2_3(Wreg_addr2_3), .RegWrite2_3(RegWrite2_3),
        .ALU_res3_4(ALU_res3_4), .Rdata23_4(Rdata23_4),
        .Wreg_addr3_4(Wreg_addr3_4), .RegWrite3_4(RegWrite3_4),
        .OP3_4(OP3_4), .stall(stall), .md_busy(md_busy), .ovf(ovf)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       nm;
        logic [5:0]  op, fn;
        logic [31:0] rs, rt, imm, pc, res;
        logic        rw, ov;
    } vec_t;

    typedef struct {
        logic [31:0] res, rd2;
        logic [4:0]  wreg;
        logic        rw;
        logic [5:0]  op;
        logic        ov;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic add(input string nm, input logic [5:0] op, fn,
                       input logic [31:0] rs, rt, imm, pc, res,
                       input logic rw, ov);
        vec_t v;
        v.nm = nm; v.op = op; v.fn = fn; v.rs = rs; v.rt = rt;
        v.imm = imm; v.pc = pc; v.res = res; v.rw = rw; v.ov = ov;
        tbl.push_back(v);
    endtask

    task automatic drv(input logic [5:0] op, fn,
                       input logic [31:0] rs, rt, imm, pc,
                       input logic [4:0] wr, input logic rw);
        OP2_3 = op; Funct2_3 = fn; Rdata12_3 = rs; Rdata22_3 = rt;
        imm2_3 = imm; next_PC2_3 = pc;
        Wreg_addr2_3 = wr; RegWrite2_3 = rw;
    endtask

    task automatic push(input logic [31:0] res, rd2,
                        input logic [4:0] wr, input logic rw,
                        input logic [5:0] op, input logic ov);
        exp_t e;
        e.res = res; e.rd2 = rd2; e.wreg = wr;
        e.rw = rw; e.op = op; e.ov = ov;
        sb.push_back(e);
    endtask

    task automatic retire(input string nm);
        exp_t e;
        @(posedge CLK);
        if (sb.size() == 0) begin
            chk({nm, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({nm, ".res"}, ALU_res3_4, e.res);
            chk({nm, ".rd2"}, Rdata23_4, e.rd2);
            chk({nm, ".wreg"}, 32'(Wreg_addr3_4), 32'(e.wreg));
            chk({nm, ".rw"}, 32'(RegWrite3_4), 32'(e.rw));
            chk({nm, ".op"}, 32'(OP3_4), 32'(e.op));
            chk({nm, ".ovf"}, 32'(ovf), 32'(e.ov));
        end
    endtask

    task automatic issue(input string nm, input logic [5:0] op, fn,
                         input logic [31:0] rs, rt, imm, pc,
                         input logic [4:0] wr, input logic rw,
                         input logic [31:0] res,
                         input logic rwo, ov);
        drv(op, fn, rs, rt, imm, pc, wr, rw);
        push(res, rt, wr, rwo, op, ov);
        #1;
        chk({nm, ".stall"}, 32'(stall), 32'd0);
        retire(nm);
    endtask

    // Hold MFHI/MFLO until stall drops, count stalled cycles.
    task automatic wait_mf(input string nm, input logic [5:0] fn,
                           input logic [31:0] expv, input int exp_n);
        int n = 0;
        drv(6'h00, fn, 32'h0, 32'h0, 32'h0, 32'h0, 5'd3, 1'b1);
        #1;
        while (stall && n < 100) begin
            n++;
            @(posedge CLK);
            #1;
        end
        chk({nm, ".stall_cycles"}, 32'(n), 32'(exp_n));
        if (n > 0)
            chk({nm, ".bubble"},
                {19'd0, RegWrite3_4, Wreg_addr3_4, OP3_4}, 32'd0);
        push(expv, 32'h0, 5'd3, 1'b1, 6'h00, 1'b0);
        retire(nm);
    endtask

    task automatic md_run(input string nm, input logic [5:0] fn,
                          input logic [31:0] rs, rt, ehi, elo);
        issue({nm, ".start"}, 6'h00, fn, rs, rt, 32'h0, 32'h0,
              5'd0, 1'b1, 32'h0, 1'b0, 1'b0);
        chk({nm, ".busy"}, 32'(md_busy), 32'd1);
        wait_mf({nm, ".lo"}, 6'h12, elo, 32);
        wait_mf({nm, ".hi"}, 6'h10, ehi, 0);
    endtask

    initial begin
        add("ADD",   6'h00, 6'h20, 32'h7FFFFFFF, 32'h1, 0, 0,
            32'h80000000, 0, 1);
        add("ADDU",  6'h00, 6'h21, 32'h7FFFFFFF, 32'h1, 0, 0,
            32'h80000000, 1, 0);
        add("SUB",   6'h00, 6'h22, 32'h80000000, 32'h1, 0, 0,
            32'h7FFFFFFF, 0, 1);
        add("SUBU",  6'h00, 6'h23, 32'h5, 32'h7, 0, 0,
            32'hFFFFFFFE, 1, 0);
        add("AND",   6'h00, 6'h24, 32'hF0F0F0F0, 32'hFF00FF00, 0, 0,
            32'hF000F000, 1, 0);
        add("OR",    6'h00, 6'h25, 32'hF0F0F0F0, 32'hFF00FF00, 0, 0,
            32'hFFF0FFF0, 1, 0);
        add("XOR",   6'h00, 6'h26, 32'hF0F0F0F0, 32'hFF00FF00, 0, 0,
            32'h0FF00FF0, 1, 0);
        add("NOR",   6'h00, 6'h27, 32'hF0F0F0F0, 32'hFF00FF00, 0, 0,
            32'h000F000F, 1, 0);
        add("SLT",   6'h00, 6'h2A, 32'hFFFFFFFF, 32'h1, 0, 0,
            32'h1, 1, 0);
        add("SLTU",  6'h00, 6'h2B, 32'hFFFFFFFF, 32'h1, 0, 0,
            32'h0, 1, 0);
        add("SLL",   6'h00, 6'h00, 32'h0, 32'h1, 32'h100, 0,
            32'h10, 1, 0);
        add("SRL",   6'h00, 6'h02, 32'h0, 32'hF0000000, 32'h100, 0,
            32'h0F000000, 1, 0);
        add("SRA",   6'h00, 6'h03, 32'h0, 32'hF0000000, 32'h100, 0,
            32'hFF000000, 1, 0);
        add("JR",    6'h00, 6'h08, 32'h1234, 32'h0, 0, 0,
            32'h0, 1, 0);
        add("ADDI",  6'h08, 6'h00, 32'h7FFFFFFF, 32'h0, 32'h1, 0,
            32'h80000000, 0, 1);
        add("ADDIU", 6'h09, 6'h00, 32'h1, 32'h0, 32'hFFFFFFFF, 0,
            32'h0, 1, 0);
        add("SLTI",  6'h0A, 6'h00, 32'hFFFFFFFB, 32'h0, 32'h3, 0,
            32'h1, 1, 0);
        add("SLTIU", 6'h0B, 6'h00, 32'h3, 32'h0, 32'hFFFFFFFF, 0,
            32'h1, 1, 0);
        add("ANDI",  6'h0C, 6'h00, 32'hFFFFFFFF, 32'h0, 32'hFFFF8000, 0,
            32'h8000, 1, 0);
        add("ORI",   6'h0D, 6'h00, 32'h0, 32'h0, 32'hFFFF8000, 0,
            32'h8000, 1, 0);
        add("XORI",  6'h0E, 6'h00, 32'h0000FFFF, 32'h0, 32'hFFFFFFFF, 0,
            32'h0, 1, 0);
        add("LUI",   6'h0F, 6'h00, 32'h0, 32'h0, 32'h1234, 0,
            32'h12340000, 1, 0);
        add("LW",    6'h23, 6'h00, 32'h1000, 32'h0, 32'hFFFFFFFC, 0,
            32'hFFC, 1, 0);
        add("SW",    6'h2B, 6'h00, 32'h1000, 32'hDEADBEEF, 32'h8, 0,
            32'h1008, 1, 0);
        add("JAL",   6'h03, 6'h00, 32'h0, 32'h0, 32'h0, 32'h400,
            32'h400, 1, 0);
        add("UNK",   6'h3F, 6'h00, 32'h55, 32'h66, 32'h77, 0,
            32'h0, 1, 0);
        add("MFHI0", 6'h00, 6'h10, 32'h0, 32'h0, 0, 0, 32'h0, 1, 0);
        add("MFLO0", 6'h00, 6'h12, 32'h0, 32'h0, 0, 0, 32'h0, 1, 0);
        add("MTHI",  6'h00, 6'h11, 32'hAAAA5555, 32'h0, 0, 0,
            32'h0, 0, 0);
        add("MFHI",  6'h00, 6'h10, 32'h0, 32'h0, 0, 0,
            32'hAAAA5555, 1, 0);
        add("MTLO",  6'h00, 6'h13, 32'h12345678, 32'h0, 0, 0,
            32'h0, 0, 0);
        add("MFLO",  6'h00, 6'h12, 32'h0, 32'h0, 0, 0,
            32'h12345678, 1, 0);

        RST = 1'b1;
        drv(6'h00, 6'h00, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
        #12;
        chk("rst.res", ALU_res3_4, 32'h0);
        chk("rst.rd2", Rdata23_4, 32'h0);
        chk("rst.ctl", {13'd0, RegWrite3_4, Wreg_addr3_4, OP3_4,
                        stall, md_busy, ovf}, 32'h0);
        @(posedge CLK);
        RST = 1'b0;

        foreach (tbl[i])
            issue(tbl[i].nm, tbl[i].op, tbl[i].fn, tbl[i].rs,
                  tbl[i].rt, tbl[i].imm, tbl[i].pc, 5'd7, 1'b1,
                  tbl[i].res, tbl[i].rw, tbl[i].ov);

        md_run("MULT", 6'h18, 32'hFFFFFFFE, 32'h3,
               32'hFFFFFFFF, 32'hFFFFFFFA);
        md_run("DIV", 6'h1A, 32'hFFFFFFF9, 32'h2,
               32'hFFFFFFFF, 32'hFFFFFFFD);
        md_run("DIVU0", 6'h1B, 32'h5, 32'h0,
               32'h5, 32'hFFFFFFFF);

        issue("MULTU.start", 6'h00, 6'h19, 32'hFFFFFFFF, 32'h2,
              0, 0, 5'd0, 1'b1, 32'h0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            issue("ADDU.bg", 6'h00, 6'h21, 32'(k), 32'h100, 0, 0,
                  5'd2, 1'b1, 32'h100 + 32'(k), 1'b1, 1'b0);
            chk("ADDU.bg.busy", 32'(md_busy), 32'd1);
        end
        issue("JAL.bg", 6'h03, 6'h00, 0, 0, 0, 32'h400,
              5'd31, 1'b1, 32'h400, 1'b1, 1'b0);
        wait_mf("MULTU.lo", 6'h12, 32'hFFFFFFFE, 28);
        wait_mf("MULTU.hi", 6'h10, 32'h1, 0);

        issue("RDIV.start", 6'h00, 6'h1A, 32'd100, 32'd3,
              0, 0, 5'd0, 1'b1, 32'h0, 1'b0, 1'b0);
        for (int k = 0; k < 9; k++)
            issue("RDIV.fill", 6'h0D, 6'h00, 32'h0, 32'h0,
                  32'h5, 0, 5'd0, 1'b0, 32'h5, 1'b0, 1'b0);
        drv(6'h00, 6'h10, 32'h0, 32'h0, 32'h0, 32'h0, 5'd4, 1'b1);
        #1;
        chk("RDIV.pre_stall", 32'(stall), 32'd1);
        #1;
        RST = 1'b1;
        #1;
        chk("RDIV.rst_busy", 32'(md_busy), 32'd0);
        chk("RDIV.rst_stall", 32'(stall), 32'd0);
        chk("RDIV.rst_res", ALU_res3_4, 32'h0);
        #1;
        RST = 1'b0;
        push(32'h0, 32'h0, 5'd4, 1'b1, 6'h00, 1'b0);
        retire("RDIV.mfhi");
        issue("RDIV.mflo", 6'h00, 6'h12, 0, 0, 0, 0,
              5'd4, 1'b1, 32'h0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
